// File: rtl/uart_time_tx.sv
// Serializes the current MM:SS time as "MM:SS\r\n" over an 8N1 UART line, LSB first.
// Transmits on request or, with auto_en, whenever the digits change from the last message sent.
module uart_time_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       resett,
  input  logic [3:0] min_m,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_m,
  input  logic [3:0] sec_l,
  input  logic       send,
  input  logic       auto_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [15:0]       msg_q, msg_d;
  logic [15:0]       last_q, last_d;
  logic              pending_q, pending_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [15:0] digits;
  logic [7:0]  cur_byte;
  logic        req;
  logic        bit_end;

  assign digits  = {min_m, min_l, sec_m, sec_l};
  assign req     = send | (auto_en & (digits != last_q));
  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = ascii_digit(msg_q[15:12]);
      3'd1:    cur_byte = ascii_digit(msg_q[11:8]);
      3'd2:    cur_byte = 8'h3A;
      3'd3:    cur_byte = ascii_digit(msg_q[7:4]);
      3'd4:    cur_byte = ascii_digit(msg_q[3:0]);
      3'd5:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    msg_d     = msg_q;
    last_d    = last_q;
    pending_d = pending_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Requests arriving mid-message collapse into a single follow-up message.
    if (state_q != StIdle && req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (req || pending_q) begin
          state_d   = StStart;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          msg_d     = digits;
          last_d    = digits;
          pending_d = 1'b0;
          baud_d    = '0;
          bit_d     = '0;
          byte_d    = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_d];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q != 3'd6) begin
            byte_d  = byte_q + 3'd1;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      msg_q     <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      msg_q     <= msg_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_time_tx.sv
// Directed bench for uart_time_tx at 10 clocks per bit; a line monitor decodes tx into bytes.
module tb_uart_time_tx;

  logic       clk = 1'b0;
  logic       resett;
  logic [3:0] min_m, min_l, sec_m, sec_l;
  logic       send, auto_en;
  logic       tx, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  int         rx_cnt;
  bit         rx_active = 1'b0;
  int         done_cnt = 0;

  uart_time_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk    (clk),
    .resett (resett),
    .min_m  (min_m),
    .min_l  (min_l),
    .sec_m  (sec_m),
    .sec_l  (sec_l),
    .send   (send),
    .auto_en(auto_en),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples mid-bit, 10 clocks per bit, dropped by reset.
  always @(negedge clk) begin
    if (!resett) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && ((rx_cnt - 15) % 10) == 0) rx_sh = {tx, rx_sh[7:1]};
      if (rx_cnt == 95) begin
        check("stop_bit", {31'b0, tx}, 32'd1);
        rx_q.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d);
    min_m = a; min_l = b; sec_m = c; sec_l = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resett = 1'b0;
    repeat (2) @(negedge clk);
    resett = 1'b1;
    @(negedge clk);
  endtask

  // Pulse send for one cycle and confirm tx falls one clock later.
  task automatic start_msg(input string tag);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check({tag, "_tx_low"}, {31'b0, tx}, 32'd0);
    check({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_msg(input string tag, input logic [55:0] exp);
    logic [7:0] got;
    for (int i = 0; i < 7; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), {24'b0, got}, {24'b0, exp[55-8*i -: 8]});
    end
  endtask

  initial begin
    int n;
    int d0;
    resett  = 1'b0;
    send    = 1'b0;
    auto_en = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    resett = 1'b1;
    @(negedge clk);

    // Basic message with exact busy length.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    d0 = done_cnt;
    start_msg("s1");
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("s1_busy_len", n, 700);
    check("s1_done", {31'b0, done}, 32'd1);
    check("s1_tx_idle", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("s1_done_pulse", {31'b0, done}, 32'd0);
    check("s1_done_cnt", done_cnt - d0, 1);
    check("s1_nbytes", rx_q.size(), 7);
    check_msg("s1", {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A});

    // Digits change mid-flight with send held: snapshot kept, follow-up after 1 idle cycle.
    start_msg("s2");
    repeat (250) @(negedge clk);
    set_digits(4'd5, 4'd9, 4'd5, 4'd9);
    send = 1'b1;
    wait_done("s2a");
    check("s2_gap_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    send = 1'b0;
    check("s2_restart_busy", {31'b0, busy}, 32'd1);
    check("s2_restart_tx", {31'b0, tx}, 32'd0);
    check("s2a_nbytes", rx_q.size(), 7);
    check_msg("s2a", {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A});
    wait_done("s2b");
    repeat (20) @(negedge clk);
    check("s2b_idle", {31'b0, busy}, 32'd0);
    check("s2b_nbytes", rx_q.size(), 7);
    check_msg("s2b", {8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A});

    // Non-BCD digits encode as '?'.
    set_digits(4'hA, 4'hF, 4'h0, 4'h9);
    start_msg("s4");
    wait_done("s4");
    @(negedge clk);
    check("s4_nbytes", rx_q.size(), 7);
    check_msg("s4", {8'h3F, 8'h3F, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A});

    // Asynchronous reset in the middle of byte 3 data.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    start_msg("s5");
    repeat (330) @(negedge clk);
    check("s5_busy_pre", {31'b0, busy}, 32'd1);
    d0 = done_cnt;
    resett = 1'b0;
    #1;
    check("s5_rst_tx", {31'b0, tx}, 32'd1);
    check("s5_rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_partial", rx_q.size(), 3);
    rx_q.delete();
    resett = 1'b1;
    @(negedge clk);
    start_msg("s5b");
    wait_done("s5b");
    @(negedge clk);
    check("s5b_nbytes", rx_q.size(), 7);
    check_msg("s5b", {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A});

    // Three requests while busy merge into one follow-up message.
    d0 = done_cnt;
    start_msg("s6");
    for (int k = 0; k < 3; k++) begin
      repeat (150) @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    wait_done("s6a");
    @(negedge clk);
    check("s6_restart", {31'b0, busy}, 32'd1);
    wait_done("s6b");
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check("s6_no_third", n, 0);
    check("s6_done_cnt", done_cnt - d0, 2);
    check("s6_nbytes", rx_q.size(), 14);
    check_msg("s6a", {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A});
    check_msg("s6b", {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A});

    // Auto mode: zero digits match the reset snapshot, a single change sends once.
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    do_reset();
    auto_en = 1'b1;
    repeat (50) @(negedge clk);
    check("s3_quiet_busy", {31'b0, busy}, 32'd0);
    check("s3_quiet_bytes", rx_q.size(), 0);
    d0 = done_cnt;
    sec_l = 4'd1;
    @(negedge clk);
    check("s3_auto_busy", {31'b0, busy}, 32'd1);
    wait_done("s3");
    repeat (800) @(negedge clk);
    check("s3_busy_after", {31'b0, busy}, 32'd0);
    check("s3_done_cnt", done_cnt - d0, 1);
    check("s3_nbytes", rx_q.size(), 7);
    check_msg("s3", {8'h30, 8'h30, 8'h3A, 8'h30, 8'h31, 8'h0D, 8'h0A});
    auto_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
